// File: rtl/fwrisc_decode.sv
// fwrisc_decode: RV32I decode / operand-fetch stage feeding the fwrisc ALU.
// Accepts one instruction per IDLE->READ->HOLD round trip, reads rs1/rs2 from
// a synchronous-read register file and presents ALU operands, op code and
// branch side-band on a valid/ready handshake.
// Optional build macro: FWRISC_DECODE_ILLEGAL_EN adds the dec_illegal output.

package fwrisc_decode_pkg;
    // Shared ALU op codes consumed by the execute stage.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LT  = 4'd5;
    localparam logic [3:0] OP_LTU = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_NE  = 4'd8;
    localparam logic [3:0] OP_GE  = 4'd9;
    localparam logic [3:0] OP_GEU = 4'd10;
    localparam logic [3:0] OP_OPA = 4'd11;
    localparam logic [3:0] OP_OPB = 4'd12;
endpackage

module fwrisc_decode
    import fwrisc_decode_pkg::*;
#(
    parameter int RESET_PC_NONE = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [4:0]  rs1_raddr,
    output logic [4:0]  rs2_raddr,
    input  logic [31:0] rs1_rdata,
    input  logic [31:0] rs2_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [3:0]  op,
    output logic [4:0]  rd,
    output logic        is_branch,
`ifdef FWRISC_DECODE_ILLEGAL_EN
    output logic [31:0] br_target,
    output logic        dec_illegal
`else
    output logic [31:0] br_target
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_HOLD
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_branch_q, is_branch_d;
    logic [31:0] br_target_q, br_target_d;
    logic        dec_valid_q, dec_valid_d;
`ifdef FWRISC_DECODE_ILLEGAL_EN
    logic        dec_illegal_q, dec_illegal_d;
`endif

    // Combinational decode results of the latched instruction.
    logic [31:0] dc_op_a, dc_op_b, dc_br_target;
    logic [3:0]  dc_op;
    logic [4:0]  dc_rd;
    logic        dc_branch, dc_legal;

    // Register-register / register-immediate funct3 share one mapping; the
    // top bit of the result flags a supported funct3.
    function automatic logic [4:0] alu_map(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_map = {1'b1, OP_ADD};
            3'b100:  alu_map = {1'b1, OP_XOR};
            3'b110:  alu_map = {1'b1, OP_OR};
            3'b111:  alu_map = {1'b1, OP_AND};
            3'b010:  alu_map = {1'b1, OP_LT};
            3'b011:  alu_map = {1'b1, OP_LTU};
            default: alu_map = {1'b0, OP_OPA};   // shifts
        endcase
    endfunction

    // Read addresses come straight from the fetch bus while idle so the
    // register file returns data in the READ cycle.
    assign rs1_raddr   = (state_q == ST_IDLE) ? instr[19:15] : instr_q[19:15];
    assign rs2_raddr   = (state_q == ST_IDLE) ? instr[24:20] : instr_q[24:20];
    assign instr_ready = (state_q == ST_IDLE);

    // Decode the latched instruction against the register data arriving now.
    always_comb begin
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1_val, rs2_val, imm_i, imm_u, imm_b;
        logic [4:0]  map;

        opcode  = instr_q[6:0];
        f3      = instr_q[14:12];
        f7      = instr_q[31:25];
        rs1_val = (instr_q[19:15] == 5'd0) ? 32'd0 : rs1_rdata;
        rs2_val = (instr_q[24:20] == 5'd0) ? 32'd0 : rs2_rdata;
        imm_i   = {{20{instr_q[31]}}, instr_q[31:20]};
        imm_u   = {instr_q[31:12], 12'd0};
        imm_b   = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                   instr_q[30:25], instr_q[11:8], 1'b0};

        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        dc_op_a      = rs1_val;
        dc_op_b      = rs2_val;
        dc_op        = OP_OPA;
        dc_rd        = instr_q[11:7];
        dc_branch    = 1'b0;
        dc_legal     = 1'b0;
        dc_br_target = pc_q + imm_b;   // wraps modulo 2^32
        map          = 5'd0;

        case (opcode)
            OPC_OP: begin
                if (f7 == 7'b0000000) begin
                    map      = alu_map(f3);
                    dc_legal = map[4];
                    dc_op    = map[3:0];
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dc_legal = 1'b1;
                    dc_op    = OP_SUB;
                end
            end
            OPC_OP_IMM: begin
                map      = alu_map(f3);
                dc_legal = map[4];
                dc_op    = map[3:0];
                dc_op_b  = imm_i;
            end
            OPC_LUI: begin
                dc_legal = 1'b1;
                dc_op    = OP_OPB;
                dc_op_a  = 32'd0;
                dc_op_b  = imm_u;
            end
            OPC_AUIPC: begin
                dc_legal = 1'b1;
                dc_op    = OP_ADD;
                dc_op_a  = pc_q;
                dc_op_b  = imm_u;
            end
            OPC_BRANCH: begin
                dc_legal  = 1'b1;
                dc_branch = 1'b1;
                dc_rd     = 5'd0;
                case (f3)
                    3'b000:  dc_op = OP_EQ;
                    3'b001:  dc_op = OP_NE;
                    3'b100:  dc_op = OP_LT;
                    3'b101:  dc_op = OP_GE;
                    3'b110:  dc_op = OP_LTU;
                    3'b111:  dc_op = OP_GEU;
                    default: dc_legal = 1'b0;
                endcase
            end
            default: dc_legal = 1'b0;
        endcase

        // Unsupported encodings pass through as a harmless no-writeback op.
        if (!dc_legal) begin
            dc_op     = OP_OPA;
            dc_rd     = 5'd0;
            dc_branch = 1'b0;
        end
    end

    // Next-state and next-output selection for the IDLE/READ/HOLD sequence.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_d          = op_q;
        rd_d          = rd_q;
        is_branch_d   = is_branch_q;
        br_target_d   = br_target_q;
        dec_valid_d   = dec_valid_q;
`ifdef FWRISC_DECODE_ILLEGAL_EN
        dec_illegal_d = dec_illegal_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    pc_d    = pc;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                op_a_d        = dc_op_a;
                op_b_d        = dc_op_b;
                op_d          = dc_op;
                rd_d          = dc_rd;
                is_branch_d   = dc_branch;
                br_target_d   = dc_br_target;
                dec_valid_d   = 1'b1;
`ifdef FWRISC_DECODE_ILLEGAL_EN
                dec_illegal_d = !dc_legal;
`endif
                state_d       = ST_HOLD;
            end
            ST_HOLD: begin
                if (dec_ready) begin
                    dec_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs, synchronously reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples its pre-edge value regardless of statement order.
        if (reset) begin
            state_q       <= ST_IDLE;
            instr_q       <= 32'd0;
            pc_q          <= 32'(RESET_PC_NONE);
            op_a_q        <= 32'd0;
            op_b_q        <= 32'd0;
            op_q          <= OP_ADD;
            rd_q          <= 5'd0;
            is_branch_q   <= 1'b0;
            br_target_q   <= 32'd0;
            dec_valid_q   <= 1'b0;
`ifdef FWRISC_DECODE_ILLEGAL_EN
            dec_illegal_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            is_branch_q   <= is_branch_d;
            br_target_q   <= br_target_d;
            dec_valid_q   <= dec_valid_d;
`ifdef FWRISC_DECODE_ILLEGAL_EN
            dec_illegal_q <= dec_illegal_d;
`endif
        end
    end

    assign dec_valid   = dec_valid_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign op          = op_q;
    assign rd          = rd_q;
    assign is_branch   = is_branch_q;
    assign br_target   = br_target_q;
`ifdef FWRISC_DECODE_ILLEGAL_EN
    assign dec_illegal = dec_illegal_q;
`endif

endmodule

// File: tb/tb_fwrisc_decode.sv
// Directed testbench for fwrisc_decode with a small synchronous-read
// register file model driving rs1_rdata/rs2_rdata.

module tb_fwrisc_decode;
    import fwrisc_decode_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [4:0]  rs1_raddr, rs2_raddr;
    logic [31:0] rs1_rdata = 32'd0;
    logic [31:0] rs2_rdata = 32'd0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] op_a, op_b, br_target;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        is_branch;
`ifdef FWRISC_DECODE_ILLEGAL_EN
    logic        dec_illegal;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] rf [32];

    always #5 clock = ~clock;

    // Register file: data valid the cycle after the address.
    always @(posedge clock) begin
        rs1_rdata <= rf[rs1_raddr];
        rs2_rdata <= rf[rs2_raddr];
    end

    fwrisc_decode #(.RESET_PC_NONE(0)) dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc(pc),
        .rs1_raddr(rs1_raddr), .rs2_raddr(rs2_raddr),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .op_a(op_a), .op_b(op_b), .op(op), .rd(rd),
        .is_branch(is_branch),
`ifdef FWRISC_DECODE_ILLEGAL_EN
        .br_target(br_target),
        .dec_illegal(dec_illegal)
`else
        .br_target(br_target)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction in IDLE; lat = edges from accept to dec_valid.
    task automatic issue(input logic [31:0] i, input logic [31:0] p, output int lat);
        instr = i;
        pc = p;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        lat = 1;
        while (dec_valid !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_instr_ready: got %b want 1", instr_ready); end
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
        total++; if (rd !== 5'd0) begin bad++; $display("FAIL reset_rd: got %0d want 0", rd); end
        total++; if (op !== OP_ADD) begin bad++; $display("FAIL reset_op: got %0d want %0d", op, OP_ADD); end
        total++; if (op_a !== 32'd0 || op_b !== 32'd0 || br_target !== 32'd0 || is_branch !== 1'b0)
            begin bad++; $display("FAIL reset_data: got a=%h b=%h t=%h br=%b want zeros", op_a, op_b, br_target, is_branch); end
`ifdef FWRISC_DECODE_ILLEGAL_EN
        total++; if (dec_illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b want 0", dec_illegal); end
`endif
    endtask

    task automatic test_add();
        int lat;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        instr = 32'h002081B3;
        #1;
        total++; if (rs1_raddr !== 5'd1 || rs2_raddr !== 5'd2)
            begin bad++; $display("FAIL add_raddr: got %0d/%0d want 1/2", rs1_raddr, rs2_raddr); end
        issue(32'h002081B3, 32'h40, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL add_latency: got %0d want 2", lat); end
        total++; if (op !== OP_ADD) begin bad++; $display("FAIL add_op: got %0d want %0d", op, OP_ADD); end
        total++; if (op_a !== 32'd5 || op_b !== 32'd7)
            begin bad++; $display("FAIL add_operands: got %h/%h want 5/7", op_a, op_b); end
        total++; if (rd !== 5'd3 || is_branch !== 1'b0)
            begin bad++; $display("FAIL add_rd: got rd=%0d br=%b want 3/0", rd, is_branch); end
`ifdef FWRISC_DECODE_ILLEGAL_EN
        total++; if (dec_illegal !== 1'b0) begin bad++; $display("FAIL add_illegal: got %b want 0", dec_illegal); end
`endif
        tick();
        total++; if (dec_valid !== 1'b0 || instr_ready !== 1'b1)
            begin bad++; $display("FAIL add_release: got v=%b r=%b want 0/1", dec_valid, instr_ready); end
    endtask

    task automatic test_alu_variants();
        int lat;
        // SUB x5,x1,x2
        issue(32'h402082B3, 32'h44, lat);
        total++; if (lat !== 2 || op !== OP_SUB || rd !== 5'd5 || op_a !== 32'd5 || op_b !== 32'd7)
            begin bad++; $display("FAIL sub: got lat=%0d op=%0d rd=%0d a=%h b=%h want 2/%0d/5/5/7", lat, op, rd, op_a, op_b, OP_SUB); end
        tick();
        // ADDI x1,x0,-1 with x0 data forced to zero
        rf[0] = 32'h1234;
        issue(32'hFFF00093, 32'h48, lat);
        total++; if (op_a !== 32'd0) begin bad++; $display("FAIL addi_x0: got %h want 0", op_a); end
        total++; if (op_b !== 32'hFFFFFFFF || rd !== 5'd1 || op !== OP_ADD)
            begin bad++; $display("FAIL addi: got b=%h rd=%0d op=%0d want ffffffff/1/%0d", op_b, rd, op, OP_ADD); end
        tick();
        rf[0] = 32'd0;
        // LUI x7,0x12345
        issue(32'h123453B7, 32'h4C, lat);
        total++; if (op !== OP_OPB || op_b !== 32'h12345000 || rd !== 5'd7)
            begin bad++; $display("FAIL lui: got op=%0d b=%h rd=%0d want %0d/12345000/7", op, op_b, rd, OP_OPB); end
        tick();
        // AUIPC x4,0x80000 at pc=0x100
        issue(32'h80000217, 32'h100, lat);
        total++; if (op !== OP_ADD || op_a !== 32'h100 || op_b !== 32'h80000000 || rd !== 5'd4)
            begin bad++; $display("FAIL auipc: got op=%0d a=%h b=%h rd=%0d want %0d/100/80000000/4", op, op_a, op_b, rd, OP_ADD); end
        tick();
    endtask

    task automatic test_branch();
        int lat;
        // BNE x1,x2,-4 at pc=0x100
        issue(32'hFE209EE3, 32'h100, lat);
        total++; if (op !== OP_NE || is_branch !== 1'b1 || rd !== 5'd0)
            begin bad++; $display("FAIL bne_ctl: got op=%0d br=%b rd=%0d want %0d/1/0", op, is_branch, rd, OP_NE); end
        total++; if (br_target !== 32'hFC) begin bad++; $display("FAIL bne_target: got %h want 000000fc", br_target); end
        total++; if (op_a !== 32'd5 || op_b !== 32'd7)
            begin bad++; $display("FAIL bne_operands: got %h/%h want 5/7", op_a, op_b); end
        tick();
        // Same branch at pc=0 wraps around
        issue(32'hFE209EE3, 32'h0, lat);
        total++; if (br_target !== 32'hFFFFFFFC) begin bad++; $display("FAIL bne_wrap: got %h want fffffffc", br_target); end
        tick();
        // BGEU x1,x2,+8 at pc=0x200
        issue(32'h0020F463, 32'h200, lat);
        total++; if (op !== OP_GEU || is_branch !== 1'b1 || br_target !== 32'h208)
            begin bad++; $display("FAIL bgeu: got op=%0d br=%b t=%h want %0d/1/208", op, is_branch, br_target, OP_GEU); end
        tick();
    endtask

    task automatic test_unsupported();
        int lat;
        // SLLI x1,x1,1: still handshaked, decodes to no-writeback OP_OPA
        issue(32'h00109093, 32'h300, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL slli_latency: got %0d want 2", lat); end
        total++; if (op !== OP_OPA || rd !== 5'd0 || is_branch !== 1'b0)
            begin bad++; $display("FAIL slli: got op=%0d rd=%0d br=%b want %0d/0/0", op, rd, is_branch, OP_OPA); end
`ifdef FWRISC_DECODE_ILLEGAL_EN
        total++; if (dec_illegal !== 1'b1) begin bad++; $display("FAIL slli_illegal: got %b want 1", dec_illegal); end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        dec_ready = 1'b0;
        issue(32'h002081B3, 32'h400, lat);
        for (int k = 0; k < 4; k++) begin
            instr = 32'h00000033;
            instr_valid = 1'b1;
            tick();
            total++; if (dec_valid !== 1'b1 || instr_ready !== 1'b0 || op_a !== 32'd5 || rd !== 5'd3 || op !== OP_ADD)
                begin bad++; $display("FAIL hold_%0d: got v=%b r=%b a=%h rd=%0d op=%0d want 1/0/5/3/%0d", k, dec_valid, instr_ready, op_a, rd, op, OP_ADD); end
        end
        instr_valid = 1'b0;
        dec_ready = 1'b1;
        tick();
        total++; if (dec_valid !== 1'b0 || instr_ready !== 1'b1)
            begin bad++; $display("FAIL hold_release: got v=%b r=%b want 0/1", dec_valid, instr_ready); end
        tick();
        tick();
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL hold_no_stale: got %b want 0", dec_valid); end
    endtask

    task automatic test_reset_in_hold();
        int lat;
        dec_ready = 1'b0;
        issue(32'h002081B3, 32'h500, lat);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (dec_valid !== 1'b0 || instr_ready !== 1'b1 || rd !== 5'd0)
            begin bad++; $display("FAIL reset_hold: got v=%b r=%b rd=%0d want 0/1/0", dec_valid, instr_ready, rd); end
        dec_ready = 1'b1;
        tick();
        // Decoder keeps working after the mid-flight reset.
        issue(32'h002081B3, 32'h504, lat);
        total++; if (lat !== 2 || rd !== 5'd3) begin bad++; $display("FAIL reset_recover: got lat=%0d rd=%0d want 2/3", lat, rd); end
        tick();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 32'd0;
        test_reset();
        test_add();
        test_alu_variants();
        test_branch();
        test_unsupported();
        test_backpressure();
        test_reset_in_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
